lfsr_rng_arbiter: RTL and testbench

Shared pseudo-random byte server: one 8-bit XNOR-feedback LFSR is time-shared between NREQ requesters through a round-robin arbiter. Each grant advances the LFSR by STEPS shifts and returns the resulting byte with a one-cycle valid strobe. A seed port lets the owning controller load the LFSR between transactions. It sits between the random-source datapath and the blocks that consume random stimulus or backoff values.

---
 rtl/lfsr_rng_arbiter_if.sv | 23 ++
 rtl/lfsr_rng_arbiter.sv | 127 ++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rng_arbiter_if.sv
// Request/grant/data bundle between the random-byte server and its requesters.
// The master side (requesters plus the seed controller) drives req, seed_load and seed.
interface lfsr_rng_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic            seed_load;
  logic [7:0]      seed;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [7:0]      rdata;
  logic            rvalid;
  logic            busy;

  modport master (
    output seed_load, seed, req,
    input  gnt, rdata, rvalid, busy
  );

  modport slave (
    input  seed_load, seed, req,
    output gnt, rdata, rvalid, busy
  );
endinterface

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbitrated server for one 8-bit XNOR LFSR; each grant yields one byte.
// Optional macro LFSR_ARB_FREERUN_EN: the LFSR also steps in IDLE cycles without a seed load.
module lfsr_rng_arbiter #(
  parameter int NREQ  = 4,
  parameter int STEPS = 8
) (
  input  logic               clk,
  input  logic               reset,
  lfsr_rng_arbiter_if.slave  bus
);

  localparam int         PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] LAST = 4'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DELIVER
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   scan_idx;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ~(v[7] ^ v[3])};
  endfunction

  // Scan upward from ptr with wrap; the first requester found wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = PW'((32'(ptr_q) + i) % NREQ);
      if (!pick_found && bus.req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (bus.seed_load) begin
          lfsr_d = (bus.seed == 8'hFF) ? 8'h00 : bus.seed;
        end else begin
`ifdef LFSR_ARB_FREERUN_EN
          lfsr_d = lfsr_step(lfsr_q);
`endif
          if (pick_found) begin
            gnt_d   = NREQ'(1) << pick_idx;
            gidx_d  = pick_idx;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        lfsr_d = lfsr_step(lfsr_q);
        cnt_d  = cnt_q + 4'd1;
        // rdata/rvalid are loaded on the last step so they are visible during DELIVER.
        if (cnt_q == LAST) begin
          rdata_d  = lfsr_step(lfsr_q);
          rvalid_d = 1'b1;
          state_d  = DELIVER;
        end
      end
      DELIVER: begin
        ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      lfsr_q   <= 8'h00;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gidx_q   <= '0;
      gnt_q    <= '0;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: directed vector table, corner sequences, randomized model check.
module tb_lfsr_rng_arbiter;
  localparam int NREQ  = 4;
  localparam int STEPS = 8;

  logic clk = 1'b0;
  logic reset;

  lfsr_rng_arbiter_if #(.NREQ(NREQ)) bus ();

  lfsr_rng_arbiter #(.NREQ(NREQ), .STEPS(STEPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic            sl;
    logic [7:0]      sd;
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] egnt;
    logic [7:0]      erd;
  } vec_t;

  vec_t tbl [6];

  // Reference model: priority list of requester ids plus the LFSR value.
  int         order [$];
  logic [7:0] m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_after(input logic [7:0] v, input int n);
    logic [7:0] x;
    x = v;
    for (int k = 0; k < n; k++) x = {x[6:0], ~(x[7] ^ x[3])};
    return x;
  endfunction

  task automatic model_reset();
    order.delete();
    for (int k = 0; k < NREQ; k++) order.push_back(k);
    m_lfsr = 8'h00;
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r);
    foreach (order[k]) if (((r >> order[k]) & 1) != 0) return order[k];
    return -1;
  endfunction

  task automatic model_grant(input int idx);
    while (order[0] != (idx + 1) % NREQ) order.push_back(order.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.seed_load = 1'b0;
    bus.seed = 8'h00;
    bus.req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One transaction: optional seed load issued together with req, then run to rvalid.
  task automatic txn(input string tag, input logic sl, input logic [7:0] sd,
                     input logic [NREQ-1:0] r, input logic [NREQ-1:0] egnt,
                     input logic [7:0] erd, input bit noisy);
    int lat;
    bit held_ok;
    bit seen;
    if (sl) begin
      bus.seed_load = 1'b1;
      bus.seed = sd;
      bus.req = r;
      tick();
      check({tag, "_sload_gnt"}, bus.gnt, 0);
      check({tag, "_sload_busy"}, bus.busy, 0);
      bus.seed_load = 1'b0;
    end
    bus.req = r;
    tick();
    bus.req = noisy ? NREQ'($urandom) : '0;
    check({tag, "_gnt"}, bus.gnt, egnt);
    lat = 0;
    held_ok = 1'b1;
    seen = 1'b0;
    while (!seen && lat < 4 * STEPS + 8) begin
      if (bus.gnt !== egnt || bus.busy !== 1'b1) held_ok = 1'b0;
      if (bus.rvalid === 1'b1) seen = 1'b1;
      else begin
        if (noisy) begin
          bus.req = NREQ'($urandom);
          bus.seed_load = 1'($urandom);
          bus.seed = 8'($urandom);
        end
        tick();
        lat++;
      end
    end
    check({tag, "_rvalid_seen"}, seen, 1);
    check({tag, "_latency"}, lat, STEPS);
    check({tag, "_gnt_held"}, held_ok, 1);
    check({tag, "_rdata"}, bus.rdata, erd);
    bus.req = '0;
    bus.seed_load = 1'b0;
    tick();
    check({tag, "_idle_gnt"}, bus.gnt, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
    check({tag, "_rvalid_pulse"}, bus.rvalid, 0);
    check({tag, "_rdata_hold"}, bus.rdata, erd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, nv, last_v, idx;
    bit oh_ok, silent;
    logic [NREQ-1:0] exp_seq [5];
    logic [NREQ-1:0] r, egnt;
    logic [7:0] sd, erd;
    logic sl;

    tbl[0] = '{1'b1, 8'h00, 4'b0001, 4'b0001, 8'hF0};
    tbl[1] = '{1'b0, 8'h00, 4'b0001, 4'b0001, 8'h0F};
    tbl[2] = '{1'b1, 8'hFF, 4'b0001, 4'b0001, 8'hF0};
    tbl[3] = '{1'b1, 8'h00, 4'b0100, 4'b0100, 8'hF0};
    tbl[4] = '{1'b0, 8'h00, 4'b1010, 4'b1000, 8'h0F};
    tbl[5] = '{1'b0, 8'h00, 4'b0011, 4'b0001, 8'h00};

    do_reset();
    check("rst_gnt", bus.gnt, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rdata", bus.rdata, 8'h00);

    for (int i = 0; i < 6; i++)
      txn($sformatf("vec%0d", i), tbl[i].sl, tbl[i].sd, tbl[i].r, tbl[i].egnt, tbl[i].erd, 1'b0);

    // All requesters held high from reset: strict rotation, one byte per STEPS+2 cycles.
    do_reset();
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req = '1;
    n = 0;
    nv = 0;
    last_v = 0;
    oh_ok = 1'b1;
    while (nv < 5 && n < 80) begin
      tick();
      n++;
      if (!$onehot0(bus.gnt)) oh_ok = 1'b0;
      if (bus.rvalid === 1'b1) begin
        check($sformatf("rr_gnt%0d", nv), bus.gnt, exp_seq[nv]);
        if (nv == 0) check("rr_first_lat", n, STEPS + 1);
        else check($sformatf("rr_gap%0d", nv), n - last_v, STEPS + 2);
        last_v = n;
        nv++;
      end
    end
    check("rr_count", nv, 5);
    check("rr_onehot", oh_ok, 1);
    bus.req = '0;

    // Reset during the third SHIFT cycle aborts the grant silently.
    do_reset();
    bus.seed_load = 1'b1;
    bus.seed = 8'h00;
    tick();
    bus.seed_load = 1'b0;
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    tick();
    tick();
    check("abort_busy_before", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_gnt", bus.gnt, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_rdata", bus.rdata, 8'h00);
    silent = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.rvalid !== 1'b0) silent = 1'b0;
      tick();
    end
    check("abort_no_rvalid", silent, 1);
    txn("post_abort", 1'b0, 8'h00, 4'b1111, 4'b0001, 8'hF0, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          sd = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
          bus.seed_load = 1'b1;
          bus.seed = sd;
          bus.req = NREQ'($urandom);
          tick();
          bus.seed_load = 1'b0;
          bus.req = '0;
          check("rnd_sload_gnt", bus.gnt, 0);
          check("rnd_sload_busy", bus.busy, 0);
          m_lfsr = (sd == 8'hFF) ? 8'h00 : sd;
        end
        1: begin
          bus.req = '0;
          repeat ($urandom_range(1, 3)) tick();
          check("rnd_gap_busy", bus.busy, 0);
        end
        default: begin
          r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
          sl = 1'($urandom);
          sd = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
          if (sl) m_lfsr = (sd == 8'hFF) ? 8'h00 : sd;
          idx = model_pick(r);
          egnt = NREQ'(1) << idx;
          erd = m_after(m_lfsr, STEPS);
          txn("rnd", sl, sd, r, egnt, erd, 1'b1);
          m_lfsr = erd;
          model_grant(idx);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
